alt_frame_sched: RTL and testbench

ALT_FRAME_SCHED -- requirements
Module: alt_frame_sched

---
 rtl/alt_pkg.sv | 20 ++
 rtl/alt_serial_div.sv | 72 +++++++
 rtl/alt_frame_sched.sv | 129 ++++++++++++
 tb/tb_alt_frame_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alt_pkg.sv
// Shared types and width constants for the alternating frame scheduler.
// Holds the raster FSM state encoding and the default frame geometry.
package alt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_FRAME_PIX = 307200;

  localparam int COORD_W  = 10;
  localparam int SUM_W    = 32;
  localparam int ERRCNT_W = 8;
  localparam int DCNT_W   = 8;

endpackage

// File: rtl/alt_serial_div.sv
// Restoring unsigned serial divider by a constant DIVISOR, one quotient bit per cycle.
// The start edge performs the first iteration so the result lands 32 cycles after start.
module alt_serial_div
  import alt_pkg::*;
#(
  parameter int DIVISOR = DEF_FRAME_PIX
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SUM_W-1:0] quotient_o
);

  localparam logic [SUM_W:0] DIV_EXT = (SUM_W+1)'(DIVISOR);

  function automatic logic [SUM_W:0] div_step(input logic [SUM_W-1:0] rem, input logic bit_in);
    logic [SUM_W:0] trial;
    trial = {rem, bit_in};
    if (trial >= DIV_EXT) return {1'b1, SUM_W'(trial - DIV_EXT)};
    else                  return {1'b0, trial[SUM_W-1:0]};
  endfunction

  logic             busy_q, done_q;
  logic [4:0]       cnt_q;
  logic [SUM_W-1:0] rem_q, quo_q, dvd_q, res_q;
  logic [SUM_W-1:0] rem_in;
  logic             bit_in;
  logic [SUM_W:0]   step;

  assign rem_in = busy_q ? rem_q : '0;
  assign bit_in = busy_q ? dvd_q[SUM_W-1] : dividend_i[SUM_W-1];
  assign step   = div_step(rem_in, bit_in);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvd_q  <= '0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        rem_q <= step[SUM_W-1:0];
        quo_q <= {quo_q[SUM_W-2:0], step[SUM_W]};
        dvd_q <= dvd_q << 1;
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          res_q  <= {quo_q[SUM_W-2:0], step[SUM_W]};
        end
      end else if (start_i) begin
        rem_q  <= step[SUM_W-1:0];
        quo_q  <= {{(SUM_W-1){1'b0}}, step[SUM_W]};
        dvd_q  <= dividend_i << 1;
        cnt_q  <= 5'd1;
        busy_q <= 1'b1;
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = res_q;

endmodule

// File: rtl/alt_frame_sched.sv
// Raster scheduler: tracks pixel coordinates, drains the datapath, then divides the frame sum.
// Optional saturating error counter is built only when ALT_SCHED_ERRCNT_EN is defined.
module alt_frame_sched
  import alt_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int FRAME_PIX = DEF_FRAME_PIX,
  parameter int PIPE_LAT  = 4
) (
  input  logic                clk_pixl,
  input  logic                reset,
  input  logic                sof_i,
  input  logic                pix_valid_i,
  input  logic [SUM_W-1:0]    acc_sum_i,
  output logic                valid_o,
  output logic [COORD_W-1:0]  syncX_o,
  output logic [COORD_W-1:0]  syncY_o,
  output logic                frame_end_o,
  output logic [SUM_W-1:0]    mean_o,
  output logic                mean_valid_o,
  output logic                frame_err_o,
  output logic [ERRCNT_W-1:0] err_cnt_o
);

  state_e             state_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [DCNT_W-1:0]  drain_cnt_q;
  logic               frame_end_q, err_q;
  logic               div_busy;
  logic               last_x, last_y, sample, start_drop, err_abort, err_drain;

  assign last_x     = (x_q == COORD_W'(H_ACTIVE - 1));
  assign last_y     = (y_q == COORD_W'(V_ACTIVE - 1));
  assign sample     = (state_q == ST_DRAIN) && (drain_cnt_q == DCNT_W'(PIPE_LAT));
  assign start_drop = sample && div_busy;
  assign err_abort  = (state_q == ST_ACTIVE) && sof_i;
  assign err_drain  = (state_q == ST_DRAIN) && sof_i;

  // An aborting sof wins over a coincident pixel: the pixel belongs to the dead frame.
  assign valid_o = (state_q == ST_ACTIVE) && pix_valid_i && !sof_i;

  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      drain_cnt_q <= '0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      frame_end_q <= 1'b0;
      if (err_abort || err_drain || start_drop) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (sof_i) begin
            state_q <= ST_ACTIVE;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        ST_ACTIVE: begin
          if (sof_i) begin
            x_q <= '0;
            y_q <= '0;
          end else if (pix_valid_i) begin
            if (!last_x) begin
              x_q <= x_q + COORD_W'(1);
            end else if (!last_y) begin
              x_q <= '0;
              y_q <= y_q + COORD_W'(1);
            end else begin
              state_q     <= ST_DRAIN;
              frame_end_q <= 1'b1;
              drain_cnt_q <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (sample) state_q <= ST_IDLE;
          else        drain_cnt_q <= drain_cnt_q + DCNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  alt_serial_div #(
    .DIVISOR(FRAME_PIX)
  ) u_div (
    .clk_i     (clk_pixl),
    .rst_ni    (reset),
    .start_i   (sample),
    .dividend_i(acc_sum_i),
    .busy_o    (div_busy),
    .done_o    (mean_valid_o),
    .quotient_o(mean_o)
  );

`ifdef ALT_SCHED_ERRCNT_EN
  function automatic logic [ERRCNT_W-1:0] sat_add(input logic [ERRCNT_W-1:0] a, input logic [1:0] n);
    logic [ERRCNT_W:0] s;
    s = {1'b0, a} + (ERRCNT_W+1)'(n);
    return s[ERRCNT_W] ? '1 : s[ERRCNT_W-1:0];
  endfunction

  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]          n_err;

  // A dropped drain sof and a dropped divider start can land in the same cycle.
  assign n_err     = 2'(err_abort | err_drain) + 2'(start_drop);
  assign err_cnt_d = sat_add(err_cnt_q, n_err);

  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  assign syncX_o     = x_q;
  assign syncY_o     = y_q;
  assign frame_end_o = frame_end_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_alt_frame_sched.sv
// Scoreboard bench for alt_frame_sched with a 4x2 frame, divisor 8, drain latency 4.
module tb_alt_frame_sched;

  localparam int H = 4, V = 2, FP = 8, PL = 4;
`ifdef ALT_SCHED_ERRCNT_EN
  localparam int ERRCNT_ON = 1;
`else
  localparam int ERRCNT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, sof_i, pix_valid_i;
  logic [31:0] acc_sum_i;
  logic        valid_o, frame_end_o, mean_valid_o, frame_err_o;
  logic [9:0]  syncX_o, syncY_o;
  logic [31:0] mean_o;
  logic [7:0]  err_cnt_o;

  alt_frame_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_PIX(FP), .PIPE_LAT(PL)) dut (
    .clk_pixl    (clk),
    .reset       (reset),
    .sof_i       (sof_i),
    .pix_valid_i (pix_valid_i),
    .acc_sum_i   (acc_sum_i),
    .valid_o     (valid_o),
    .syncX_o     (syncX_o),
    .syncY_o     (syncY_o),
    .frame_end_o (frame_end_o),
    .mean_o      (mean_o),
    .mean_valid_o(mean_valid_o),
    .frame_err_o (frame_err_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] val; int cyc; } mean_t;
  mean_t       mq[$];
  int          fq[$];
  logic [19:0] cq[$];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: pops expectations as the DUT produces them.
  always @(negedge clk) begin
    if (valid_o) begin
      if (cq.size() == 0) chk("valid_unexp", valid_o, 0);
      else begin
        logic [19:0] e;
        e = cq.pop_front();
        chk("coord", {syncX_o, syncY_o}, e);
      end
    end
    if (frame_end_o) begin
      if (fq.size() == 0) chk("fe_unexp", frame_end_o, 0);
      else chk("fe_cyc", cyc, fq.pop_front());
    end
    if (mean_valid_o) begin
      if (mq.size() == 0) chk("mean_unexp", mean_valid_o, 0);
      else begin
        mean_t m;
        m = mq.pop_front();
        chk("mean", mean_o, m.val);
        chk("mean_cyc", cyc, m.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_frame(input logic [31:0] acc, input int gap, input bit expect_mean, input bit do_sof);
    int t_last;
    t_last = 0;
    if (do_sof) begin
      sof_i = 1'b1; acc_sum_i = acc;
      step();
      sof_i = 1'b0;
    end
    for (int i = 0; i < H*V; i++) begin
      for (int g = 0; g < gap; g++) begin
        pix_valid_i = 1'b0;
        step();
      end
      pix_valid_i = 1'b1;
      cq.push_back({10'(i % H), 10'(i / H)});
      t_last = cyc;
      step();
    end
    pix_valid_i = 1'b0;
    fq.push_back(t_last + 1);
    if (expect_mean) mq.push_back('{val: acc / FP, cyc: t_last + PL + 1 + 32});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || fq.size() != 0 || cq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", (n < 200), 1);
    repeat (40) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    reset = 1'b0; sof_i = 1'b0; pix_valid_i = 1'b0; acc_sum_i = '0;
    repeat (3) step();
    chk("rst_valid", valid_o, 0);
    chk("rst_x", syncX_o, 0);
    chk("rst_y", syncY_o, 0);
    chk("rst_fe", frame_end_o, 0);
    chk("rst_mean", mean_o, 0);
    chk("rst_mv", mean_valid_o, 0);
    chk("rst_err", frame_err_o, 0);
    chk("rst_cnt", err_cnt_o, 0);
    reset = 1'b1;
    repeat (2) step();

    // Contiguous frame, then gapped frame, then boundary and random sums.
    run_frame(32'd100, 0, 1, 1);
    wait_drain();
    chk("mean_hold", mean_o, 12);
    chk("err_clean", frame_err_o, 0);
    run_frame(32'd100, 2, 1, 1);
    wait_drain();
    run_frame(32'hFFFF_FFFF, 0, 1, 1);
    wait_drain();
    chk("mean_max_hold", mean_o, 536870911);
    r = $urandom;
    run_frame(r, 1, 1, 1);
    wait_drain();
    chk("err_still_clean", frame_err_o, 0);

    // Second frame ends while the first division is still running.
    run_frame(32'd200, 0, 1, 1);
    repeat (5) step();
    run_frame(32'd80, 0, 0, 1);
    wait_drain();
    chk("overrun_err", frame_err_o, 1);
    chk("overrun_cnt", err_cnt_o, ERRCNT_ON ? 1 : 0);
    chk("overrun_mean", mean_o, 25);

    // Abort after three pixels, then complete the restarted frame.
    sof_i = 1'b1; acc_sum_i = 32'd40;
    step();
    sof_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_valid_i = 1'b1;
      cq.push_back({10'(i), 10'd0});
      step();
    end
    pix_valid_i = 1'b0;
    sof_i = 1'b1;
    step();
    sof_i = 1'b0;
    chk("abort_err", frame_err_o, 1);
    chk("abort_cnt", err_cnt_o, ERRCNT_ON ? 2 : 0);
    chk("abort_x", syncX_o, 0);
    chk("abort_y", syncY_o, 0);
    run_frame(32'd40, 0, 1, 0);
    wait_drain();

    // Reset during the tenth division iteration.
    run_frame(32'd1000, 0, 0, 1);
    repeat (14) step();
    reset = 1'b0;
    #1;
    chk("mid_valid", valid_o, 0);
    chk("mid_x", syncX_o, 0);
    chk("mid_y", syncY_o, 0);
    chk("mid_fe", frame_end_o, 0);
    chk("mid_mean", mean_o, 0);
    chk("mid_mv", mean_valid_o, 0);
    chk("mid_err", frame_err_o, 0);
    chk("mid_cnt", err_cnt_o, 0);
    repeat (3) step();
    reset = 1'b1;
    repeat (60) step();
    chk("post_mean", mean_o, 0);
    chk("post_err", frame_err_o, 0);

    chk("cq_empty", cq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    chk("mq_empty", mq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
